// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller: initialiser
// states, preload table contents and byte geometry.
package data_mem_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned PRELOAD_W   = 16;
  localparam int unsigned PRELOAD_LEN = 8;

  // Boot image written into the lowest addresses; everything above is zeroed.
  function automatic logic [PRELOAD_W-1:0] preload_word(input int unsigned idx);
    logic [PRELOAD_W-1:0] word;
    case (idx)
      0:       word = 16'h000a;
      1:       word = 16'h0009;
      2:       word = 16'h0006;
      3:       word = 16'h0005;
      4:       word = 16'h0001;
      5:       word = 16'h0004;
      6:       word = 16'h0003;
      7:       word = 16'h0011;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset initialiser: walks every address once, emitting one write per
// cycle (preload word or zero), then raises ready and parks in RUN.
module mem_init_seq
  import data_mem_pkg::*;
#(
  parameter  int unsigned DW    = 16,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic [DW-1:0] init_data,
  output logic          ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  init_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [DW-1:0] data_q, data_d;
  logic          ready_q, ready_d;

  // Preload entries are 16 bits; the cast zero-extends or truncates to DW.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] idx);
    logic [DW-1:0] word;
    if (32'(idx) < PRELOAD_LEN) begin
      word = DW'(preload_word(32'(idx)));
    end else begin
      word = '0;
    end
    return word;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    data_d  = data_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = RUN;
          we_d    = 1'b0;
          ready_d = 1'b1;
        end else begin
          ptr_d  = ptr_q + AW'(1);
          data_d = init_word(ptr_d);
        end
      end
      RUN: begin
        we_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Write data is precomputed one step ahead so every output comes from a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      we_q    <= 1'b1;
      data_q  <= init_word('0);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign init_we   = we_q;
  assign init_addr = ptr_q;
  assign init_data = data_q;
  assign ready     = ready_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Parametrised CPU data memory: byte-enabled writes, 0- or 1-cycle reads,
// and a sequential initialiser that owns the array after every reset.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter  int unsigned DW       = 16,
  parameter  int unsigned DEPTH    = 256,
  parameter  int unsigned READ_LAT = 0,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned NB       = DW / BYTE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [NB-1:0] be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          ready
);

  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] rd_old_c;
  logic [DW-1:0] wr_merge_c;
  logic          user_wr_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [DW-1:0] rd_comb_c;

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  mem_init_seq #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .ready     (ready)
  );

  always_comb begin
    rd_old_c   = mem_q[addr];
    user_wr_c  = rst & ready & we;
    wr_merge_c = rd_old_c;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) begin
        wr_merge_c[BYTE_W*i +: BYTE_W] = wdata[BYTE_W*i +: BYTE_W];
      end
    end

    // Initialiser and user port never overlap: ready is low for all of INIT.
    wr_en_c   = 1'b0;
    wr_addr_c = addr;
    wr_data_c = wr_merge_c;
    if (rst && init_we) begin
      wr_en_c   = 1'b1;
      wr_addr_c = init_addr;
      wr_data_c = init_data;
    end else if (user_wr_c) begin
      wr_en_c = 1'b1;
    end

    // Registered read is write-first: a same-cycle write forwards its merged word.
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (ready && re) begin
      rdata_d  = user_wr_c ? wr_merge_c : rd_old_c;
      rvalid_d = 1'b1;
    end

    rd_comb_c = ready ? rd_old_c : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_c] <= wr_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = (READ_LAT != 0) ? rdata_q  : rd_comb_c;
  assign rvalid = (READ_LAT != 0) ? rvalid_q : (re & ready);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl: one instance per read latency, both
// checked every cycle against a word-level reference model plus directed cases.
module tb_data_mem_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned NB    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic          re;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          ready0, ready1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] pre_tbl [8] = '{16'h000a, 16'h0009, 16'h0006, 16'h0005,
                               16'h0001, 16'h0004, 16'h0003, 16'h0011};

  // Reference model state
  logic [15:0] ref_mem [DEPTH];
  bit          ref_live = 1'b0;
  bit          ref_ready;
  int          ref_init_left;
  logic [15:0] ref_rd1;
  bit          ref_rv1;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .we(we), .be(be), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .ready(ready0)
  );

  data_mem_ctrl #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .be(be), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .ready(ready1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied in that cycle.
  task automatic ref_edge();
    logic [15:0] old_w, new_w;
    if (!rst) begin
      ref_live      = 1'b1;
      ref_ready     = 1'b0;
      ref_init_left = DEPTH;
      ref_rv1       = 1'b0;
      ref_rd1       = 16'h0;
      return;
    end
    if (!ref_live) return;
    if (!ref_ready) begin
      ref_rv1 = 1'b0;
      ref_init_left--;
      if (ref_init_left == 0) begin
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = (a < 8) ? pre_tbl[a] : 16'h0;
        ref_ready = 1'b1;
      end
      return;
    end
    old_w = ref_mem[addr];
    new_w = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) new_w[8*i +: 8] = wdata[8*i +: 8];
    if (re) begin
      ref_rd1 = we ? new_w : old_w;
      ref_rv1 = 1'b1;
    end else begin
      ref_rv1 = 1'b0;
    end
    if (we) ref_mem[addr] = new_w;
  endtask

  task automatic ref_check();
    if (!ref_live) return;
    check_eq("ready0", 32'(ready0), 32'(ref_ready));
    check_eq("ready1", 32'(ready1), 32'(ref_ready));
    check_eq("rvalid0", 32'(rvalid0), 32'(re & ref_ready));
    check_eq("rdata0", 32'(rdata0), 32'(ref_ready ? ref_mem[addr] : 16'h0));
    check_eq("rvalid1", 32'(rvalid1), 32'(ref_rv1));
    check_eq("rdata1", 32'(rdata1), 32'(ref_rd1));
  endtask

  // Inputs are set after posedge+1; checks at negedge; returns at posedge+1.
  task automatic run_cycle(input bit dchk, input string tag, input logic [15:0] dexp);
    @(negedge clk);
    ref_check();
    if (dchk) check_eq(tag, 32'(rdata0), 32'(dexp));
    @(posedge clk);
    ref_edge();
    #1;
  endtask

  task automatic tick();
    run_cycle(1'b0, "", 16'h0);
  endtask

  task automatic tick_rd0(input string tag, input logic [15:0] exp);
    run_cycle(1'b1, tag, exp);
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; be = '0; addr = '0; wdata = '0;
  endtask

  // Runs INIT under random traffic and checks it takes exactly DEPTH cycles.
  task automatic wait_init(input string tag);
    int n = 0;
    while (ready0 !== 1'b1 && n < 400) begin
      we = 1'(($urandom_range(0, 1))); re = 1'(($urandom_range(0, 1)));
      be = NB'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
      if (n == 10) begin
        we = 1'b1; re = 1'b1; be = 2'b11; addr = 8'd9; wdata = 16'h7777;
      end
      tick();
      n++;
    end
    idle();
    check_eq({tag, "_cycles"}, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (3) tick();
    check_eq("rst_ready0", 32'(ready0), 32'd0);
    check_eq("rst_rvalid1", 32'(rvalid1), 32'd0);
    check_eq("rst_rdata1", 32'(rdata1), 32'd0);
    rst = 1'b1;
    wait_init("init1");

    // Preload image and zeroed tail, through both read paths
    for (int a = 0; a < 11; a++) begin
      logic [15:0] exp;
      case (a)
        8:       begin addr = 8'd8;   exp = 16'h0; end
        9:       begin addr = 8'd255; exp = 16'h0; end
        10:      begin addr = 8'd9;   exp = 16'h0; end
        default: begin addr = AW'(a); exp = pre_tbl[a]; end
      endcase
      re = 1'b1;
      tick_rd0($sformatf("pre0_a%0d", addr), exp);
      check_eq($sformatf("pre1_a%0d", addr), 32'(rdata1), 32'(exp));
      check_eq("pre1_rvalid", 32'(rvalid1), 32'd1);
    end
    idle();

    // Byte-enable writes
    we = 1'b1; addr = 8'd3; wdata = 16'hABCD; be = 2'b10;
    tick();
    idle(); re = 1'b1; addr = 8'd3;
    tick_rd0("be_hi", 16'hAB05);
    check_eq("be_hi1", 32'(rdata1), 32'hAB05);
    we = 1'b1; re = 1'b0; addr = 8'd4; wdata = 16'hFFFF; be = 2'b00;
    tick();
    idle(); re = 1'b1; addr = 8'd4;
    tick_rd0("be_none", 16'h0001);

    // Registered read forwards a same-cycle write
    re = 1'b1; we = 1'b1; addr = 8'd7; wdata = 16'h1234; be = 2'b11;
    tick();
    check_eq("fwd_rvalid", 32'(rvalid1), 32'd1);
    check_eq("fwd_rdata", 32'(rdata1), 32'h1234);
    idle();
    tick();
    check_eq("hold_rvalid", 32'(rvalid1), 32'd0);
    check_eq("hold_rdata", 32'(rdata1), 32'h1234);

    // Combinational read sees old data during a same-address write
    re = 1'b1; we = 1'b1; addr = 8'd0; wdata = 16'hFFFF; be = 2'b11;
    tick_rd0("raw_old", 16'h000a);
    we = 1'b0;
    tick_rd0("raw_new", 16'hFFFF);

    // Reset in RUN reruns the initialiser
    idle(); we = 1'b1; addr = 8'd2; wdata = 16'h5555; be = 2'b11;
    tick();
    idle(); re = 1'b1; addr = 8'd2;
    tick_rd0("pre_rst_a2", 16'h5555);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_ready", 32'(ready0), 32'd0);
    check_eq("mid_rst_rvalid0", 32'(rvalid0), 32'd0);
    check_eq("mid_rst_rvalid1", 32'(rvalid1), 32'd0);
    check_eq("mid_rst_rdata1", 32'(rdata1), 32'd0);
    rst = 1'b1;
    wait_init("init2");
    re = 1'b1; addr = 8'd2;
    tick_rd0("post_rst_a2", 16'h0006);
    addr = 8'd9;
    tick_rd0("post_rst_a9", 16'h0000);

    // Random traffic with rare resets
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 999) != 0);
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      be    = NB'($urandom);
      addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      wdata = DW'($urandom);
      tick();
    end
    rst = 1'b1;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
